// File: rtl/monociclo_multiciclo.sv
// Multicycle RV32I-subset core (R, I-ALU, LW, SW, BEQ/BNE, JAL) on one shared req/ready memory port.
// Define MULTICICLO_PERF_EN to build the cycle and retired-instruction counters.
module monociclo_multiciclo #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 32,
    parameter int          NREGS    = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [31:0]       salida_o,
    output logic              halt_o,
    output logic [31:0]       perf_cycles_o,
    output logic [31:0]       perf_instret_o
);
    localparam int RW = $clog2(NREGS);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, pc_old_q, pc_old_d, ir_q, ir_d, mdr_q, mdr_d;
    logic [31:0] a_q, a_d, b_q, b_d, alu_out_q, alu_out_d, salida_q, salida_d;
    logic [31:0] rf [NREGS];

    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2, shamt;
    logic [31:0] imm_i, imm_s, imm_b, imm_j;
    logic        is_r, is_lw, is_sw, is_br, is_jal, legal, rf_we;
    logic [31:0] op2, alu_res, ls_addr, wb_val, rs1_val, rs2_val;

    function automatic logic reg_ok(input logic [4:0] idx);
        return {27'b0, idx} < 32'(NREGS);
    endfunction

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    assign is_r   = (opcode == OP_R);
    assign is_lw  = (opcode == OP_LW);
    assign is_sw  = (opcode == OP_SW);
    assign is_br  = (opcode == OP_BR);
    assign is_jal = (opcode == OP_JAL);

    assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf[rs1[RW-1:0]];
    assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf[rs2[RW-1:0]];
    assign ls_addr = a_q + (is_sw ? imm_s : imm_i);
    assign wb_val  = is_lw ? mdr_q : alu_out_q;

    // Only register fields actually used by each format are range-checked.
    always_comb begin
        legal = 1'b0;
        case (opcode)
            OP_R:    legal = ((funct7 == 7'b0000000) ||
                              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)))
                             && reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2);
            OP_I:    legal = ((funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                              (funct3 == 3'b101) ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) :
                              1'b1) && reg_ok(rd) && reg_ok(rs1);
            OP_LW:   legal = (funct3 == 3'b010) && reg_ok(rd) && reg_ok(rs1);
            OP_SW:   legal = (funct3 == 3'b010) && reg_ok(rs1) && reg_ok(rs2);
            OP_BR:   legal = (funct3 == 3'b000 || funct3 == 3'b001) && reg_ok(rs1) && reg_ok(rs2);
            OP_JAL:  legal = reg_ok(rd);
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        op2   = is_r ? b_q : imm_i;
        shamt = op2[4:0];
        case (funct3)
            3'b000:  alu_res = (is_r && funct7[5]) ? a_q - op2 : a_q + op2;
            3'b001:  alu_res = a_q << shamt;
            3'b010:  alu_res = {31'b0, $signed(a_q) < $signed(op2)};
            3'b011:  alu_res = {31'b0, a_q < op2};
            3'b100:  alu_res = a_q ^ op2;
            3'b101:  alu_res = funct7[5] ? $unsigned($signed(a_q) >>> shamt) : a_q >> shamt;
            3'b110:  alu_res = a_q | op2;
            default: alu_res = a_q & op2;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_old_d  = pc_old_q;
        ir_d      = ir_q;
        mdr_d     = mdr_q;
        a_d       = a_q;
        b_d       = b_q;
        alu_out_d = alu_out_q;
        salida_d  = salida_q;
        rf_we     = 1'b0;
        case (state_q)
            FETCH: if (mem_ready_i) begin
                ir_d     = mem_rdata_i;
                pc_old_d = pc_q;
                pc_d     = pc_q + 32'd4;
                state_d  = DECODE;
            end
            DECODE: begin
                a_d       = rs1_val;
                b_d       = rs2_val;
                alu_out_d = pc_old_q + imm_b;
                if (legal) begin
                    state_d = EXEC;
                end else begin
                    state_d = HALT;
                    pc_d    = pc_old_q;
                end
            end
            EXEC: begin
                if (is_lw || is_sw) begin
                    alu_out_d = ls_addr;
                    if (ls_addr[1:0] != 2'b00) begin
                        state_d = HALT;
                        pc_d    = pc_old_q;
                    end else begin
                        state_d = MEM;
                    end
                end else if (is_br) begin
                    if ((a_q == b_q) ^ funct3[0]) pc_d = alu_out_q;
                    state_d = FETCH;
                end else if (is_jal) begin
                    alu_out_d = pc_q;
                    pc_d      = pc_old_q + imm_j;
                    state_d   = WB;
                end else begin
                    alu_out_d = alu_res;
                    state_d   = WB;
                end
            end
            MEM: if (mem_ready_i) begin
                if (is_lw) begin
                    mdr_d   = mem_rdata_i;
                    state_d = WB;
                end else begin
                    state_d = FETCH;
                end
            end
            WB: begin
                rf_we    = (rd != 5'd0);
                salida_d = wb_val;
                state_d  = FETCH;
            end
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FETCH;
            pc_q      <= RESET_PC;
            pc_old_q  <= RESET_PC;
            ir_q      <= 32'h0;
            mdr_q     <= 32'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            alu_out_q <= 32'h0;
            salida_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_old_q  <= pc_old_d;
            ir_q      <= ir_d;
            mdr_q     <= mdr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            alu_out_q <= alu_out_d;
            salida_q  <= salida_d;
        end
    end

    // The register file is deliberately left out of reset.
    always_ff @(posedge clk_i) begin
        if (rf_we) rf[rd[RW-1:0]] <= wb_val;
    end

    // Gating with rst_ni drops the request the instant reset is asserted.
    assign mem_req_o   = rst_ni && (state_q == FETCH || state_q == MEM);
    assign mem_we_o    = rst_ni && (state_q == MEM) && is_sw;
    assign mem_addr_o  = (state_q == MEM) ? alu_out_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
    assign mem_wdata_o = b_q;
    assign salida_o    = salida_q;
    assign halt_o      = (state_q == HALT);

`ifdef MULTICICLO_PERF_EN
    logic [31:0] cycles_q, cycles_d, instret_q, instret_d;

    always_comb begin
        cycles_d  = cycles_q + {31'b0, state_q != HALT};
        instret_d = instret_q + {31'b0, (state_q != FETCH) && (state_d == FETCH)};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycles_q  <= 32'h0;
            instret_q <= 32'h0;
        end else begin
            cycles_q  <= cycles_d;
            instret_q <= instret_d;
        end
    end

    assign perf_cycles_o  = cycles_q;
    assign perf_instret_o = instret_q;
`else
    assign perf_cycles_o  = 32'h0;
    assign perf_instret_o = 32'h0;
`endif
endmodule
